// File: rtl/data_mem_responder_pkg.sv
// Shared controls for the data memory responder: RV32I load/store size codes,
// FSM state encoding and a funct3 legality helper.
package data_mem_responder_pkg;

    localparam logic [2:0] Funct3B  = 3'b000;
    localparam logic [2:0] Funct3H  = 3'b001;
    localparam logic [2:0] Funct3W  = 3'b010;
    localparam logic [2:0] Funct3Bu = 3'b100;
    localparam logic [2:0] Funct3Hu = 3'b101;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StWait = 2'd1;
    localparam state_t StResp = 2'd2;

    // Unsigned sizes only make sense for loads.
    function automatic logic funct3_legal(input logic [2:0] funct3, input logic is_store);
        logic legal;
        case (funct3)
            Funct3B, Funct3H, Funct3W: legal = 1'b1;
            Funct3Bu, Funct3Hu:        legal = !is_store;
            default:                   legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between a processor (master) and the data memory
// responder (slave).
interface data_mem_responder_if #(
    parameter int unsigned REG_WIDTH = 32
) ();

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [2:0]           req_funct3;
    logic [REG_WIDTH-1:0] req_addr;
    logic [REG_WIDTH-1:0] req_wdata;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [REG_WIDTH-1:0] resp_rdata;
    logic                 resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/data_mem_responder_lsu_align.sv
// Byte-lane alignment: store shifting and byte enables, load lane select and
// extension, plus size/alignment legality.
module lsu_align
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned REG_WIDTH = 32
) (
    input  logic                   we_i,
    input  logic [2:0]             funct3_i,
    input  logic [1:0]             off_i,
    input  logic [REG_WIDTH-1:0]   wdata_i,
    input  logic [REG_WIDTH-1:0]   rword_i,
    output logic [REG_WIDTH-1:0]   wword_o,
    output logic [REG_WIDTH/8-1:0] be_o,
    output logic [REG_WIDTH-1:0]   rdata_o,
    output logic                   err_o
);

    localparam int unsigned NB = REG_WIDTH / 8;

    logic [4:0]           shamt;
    logic [REG_WIDTH-1:0] shifted;

    always_comb begin
        shamt   = {off_i, 3'b000};
        shifted = rword_i >> shamt;
        wword_o = wdata_i << shamt;
        be_o    = '0;
        rdata_o = '0;
        err_o   = !funct3_legal(funct3_i, we_i);
        case (funct3_i)
            Funct3B: begin
                be_o    = NB'(1) << off_i;
                rdata_o = {{(REG_WIDTH-8){shifted[7]}}, shifted[7:0]};
            end
            Funct3Bu: begin
                rdata_o = {{(REG_WIDTH-8){1'b0}}, shifted[7:0]};
            end
            Funct3H: begin
                be_o    = NB'(3) << off_i;
                rdata_o = {{(REG_WIDTH-16){shifted[15]}}, shifted[15:0]};
                err_o   = err_o | off_i[0];
            end
            Funct3Hu: begin
                rdata_o = {{(REG_WIDTH-16){1'b0}}, shifted[15:0]};
                err_o   = err_o | off_i[0];
            end
            Funct3W: begin
                be_o    = '1;
                rdata_o = shifted;
                err_o   = err_o | (off_i != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Word-organised data memory answering one load/store at a time with a fixed
// WAIT_CYCLES latency; memory is committed/read on entry into the response state.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned REG_WIDTH    = 32,
    parameter int unsigned NUM_MEM_LOCS = 64,
    parameter int unsigned WAIT_CYCLES  = 1
) (
    input logic                   clk,
    input logic                   rst,
    data_mem_responder_if.slave   mem_bus
);

    localparam int unsigned IdxW     = $clog2(NUM_MEM_LOCS);
    localparam int unsigned NB       = REG_WIDTH / 8;
    localparam logic [3:0]  WaitInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 we_q;
    logic [2:0]           f3_q;
    logic [REG_WIDTH-1:0] addr_q, wdata_q;
    logic [REG_WIDTH-1:0] rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic [REG_WIDTH-1:0] mem [NUM_MEM_LOCS];

    logic                 accept, enter_resp;
    logic                 op_we;
    logic [2:0]           op_f3;
    logic [REG_WIDTH-1:0] op_addr, op_wdata;
    logic [IdxW-1:0]      idx;
    logic                 range_err, align_err, op_err;
    logic [REG_WIDTH-1:0] wword, ldata;
    logic [NB-1:0]        be;

    assign accept = (state_q == StIdle) && mem_bus.req_valid;

    // With no wait state the commit happens on the accept edge, so operands
    // must come straight from the bus rather than from the latch.
    always_comb begin
        if (state_q == StIdle) begin
            op_we    = mem_bus.req_we;
            op_f3    = mem_bus.req_funct3;
            op_addr  = mem_bus.req_addr;
            op_wdata = mem_bus.req_wdata;
        end else begin
            op_we    = we_q;
            op_f3    = f3_q;
            op_addr  = addr_q;
            op_wdata = wdata_q;
        end
    end

    assign idx       = op_addr[IdxW+1:2];
    assign range_err = (op_addr >> 2) >= REG_WIDTH'(NUM_MEM_LOCS);
    assign op_err    = range_err | align_err;

    lsu_align #(
        .REG_WIDTH(REG_WIDTH)
    ) u_lsu_align (
        .we_i    (op_we),
        .funct3_i(op_f3),
        .off_i   (op_addr[1:0]),
        .wdata_i (op_wdata),
        .rword_i (mem[idx]),
        .wword_o (wword),
        .be_o    (be),
        .rdata_o (ldata),
        .err_o   (align_err)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            StIdle: begin
                if (mem_bus.req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d    = StResp;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = WaitInit;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d    = StResp;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (mem_bus.resp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign rdata_d = (op_we || op_err) ? '0 : ldata;
    assign err_d   = op_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= mem_bus.req_we;
                f3_q    <= mem_bus.req_funct3;
                addr_q  <= mem_bus.req_addr;
                wdata_q <= mem_bus.req_wdata;
            end
            if (enter_resp) begin
                rdata_q <= rdata_d;
                err_q   <= err_d;
            end
        end
    end

    // Contents survive reset; only a store reaching the response state commits.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && op_we && !op_err) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
            end
        end
    end

    assign mem_bus.req_ready  = (state_q == StIdle);
    assign mem_bus.resp_valid = (state_q == StResp);
    assign mem_bus.resp_rdata = (state_q == StResp) ? rdata_q : '0;
    assign mem_bus.resp_err   = (state_q == StResp) ? err_q : 1'b0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: a byte-array reference model predicts each response at
// accept time; a negedge monitor checks responses, latency and handshakes.
module tb_data_mem_responder;

    localparam int unsigned RW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder_if #(.REG_WIDTH(RW)) bus1 ();
    data_mem_responder_if #(.REG_WIDTH(RW)) bus3 ();

    data_mem_responder #(
        .REG_WIDTH(RW), .NUM_MEM_LOCS(64), .WAIT_CYCLES(1)
    ) dut1 (
        .clk    (clk),
        .rst    (rst),
        .mem_bus(bus1)
    );

    data_mem_responder #(
        .REG_WIDTH(RW), .NUM_MEM_LOCS(64), .WAIT_CYCLES(3)
    ) dut3 (
        .clk    (clk),
        .rst    (rst),
        .mem_bus(bus3)
    );

    logic        drv_valid = 1'b0;
    logic        drv_we    = 1'b0;
    logic [2:0]  drv_f3    = 3'b000;
    logic [31:0] drv_addr  = '0;
    logic [31:0] drv_wdata = '0;
    logic        sel       = 1'b0;
    logic        rdy;
    bit          rand_rdy   = 1'b0;
    logic        forced_rdy = 1'b1;

    assign bus1.req_valid  = drv_valid & ~sel;
    assign bus1.req_we     = drv_we;
    assign bus1.req_funct3 = drv_f3;
    assign bus1.req_addr   = drv_addr;
    assign bus1.req_wdata  = drv_wdata;
    assign bus1.resp_ready = rdy & ~sel;
    assign bus3.req_valid  = drv_valid & sel;
    assign bus3.req_we     = drv_we;
    assign bus3.req_funct3 = drv_f3;
    assign bus3.req_addr   = drv_addr;
    assign bus3.req_wdata  = drv_wdata;
    assign bus3.resp_ready = rdy & sel;

    wire        mon_req_ready  = sel ? bus3.req_ready  : bus1.req_ready;
    wire        mon_resp_valid = sel ? bus3.resp_valid : bus1.resp_valid;
    wire        mon_resp_ready = sel ? bus3.resp_ready : bus1.resp_ready;
    wire [31:0] mon_resp_rdata = sel ? bus3.resp_rdata : bus1.resp_rdata;
    wire        mon_resp_err   = sel ? bus3.resp_err   : bus1.resp_err;

    always @(posedge clk) begin
        #1;
        rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : forced_rdy;
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mem_m [2][256];
    int         n_run  = 0;
    int         n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: memory as a flat byte array, RV32I little-endian semantics.
    function automatic void model(input int which, input logic we, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic [31:0] rd, output logic err);
        int          n;
        logic [31:0] v;
        n   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        err = (f3 == 3'd3) || (f3 >= 3'd6) || (we && f3[2]) || (addr >= 32'd256) ||
              (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'd0);
        rd  = '0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < n; i++) mem_m[which][int'(addr[7:0]) + i] = wdata[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = mem_m[which][int'(addr[7:0]) + i];
                if (!f3[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
                if (!f3[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
                rd = v;
            end
        end
    endfunction

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit use_exp,
                          input logic [31:0] exp_rd, input logic exp_err, input bit abort);
        exp_t        e;
        logic [31:0] mrd;
        logic        merr;
        int          t;
        @(negedge clk);
        drv_valid = 1'b1;
        drv_we    = we;
        drv_f3    = f3;
        drv_addr  = addr;
        drv_wdata = wdata;
        t = 0;
        while (!mon_req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!mon_req_ready) begin
            check("req_ready_timeout", 32'(mon_req_ready), 32'd1);
            drv_valid = 1'b0;
            return;
        end
        if (!abort) begin
            model(sel ? 1 : 0, we, f3, addr, wdata, mrd, merr);
            e.rdata = use_exp ? exp_rd : mrd;
            e.err   = use_exp ? exp_err : merr;
            e.lat   = sel ? 4 : 2;
            e.acc   = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        drv_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain_outstanding", 32'(sb.size()), 32'd0);
    endtask

    bit mon_en  = 1'b0;
    bit in_resp = 1'b0;
    bit chk_rdy = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (chk_rdy) begin
                check("req_ready_after_resp", 32'(mon_req_ready), 32'd1);
                chk_rdy = 1'b0;
            end
            if (mon_resp_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp_valid", 32'(mon_resp_valid), 32'd0);
                end else begin
                    if (!in_resp) begin
                        check("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
                        in_resp = 1'b1;
                    end
                    check("resp_rdata", mon_resp_rdata, sb[0].rdata);
                    check("resp_err", 32'(mon_resp_err), 32'(sb[0].err));
                    check("req_ready_in_resp", 32'(mon_req_ready), 32'd0);
                    if (mon_resp_ready) begin
                        void'(sb.pop_front());
                        in_resp = 1'b0;
                        chk_rdy = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        int t;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready_w1", 32'(bus1.req_ready), 32'd1);
        check("rst_resp_valid_w1", 32'(bus1.resp_valid), 32'd0);
        check("rst_resp_rdata_w1", bus1.resp_rdata, 32'd0);
        check("rst_resp_err_w1", 32'(bus1.resp_err), 32'd0);
        check("rst_req_ready_w3", 32'(bus3.req_ready), 32'd1);
        check("rst_resp_valid_w3", 32'(bus3.resp_valid), 32'd0);
        mon_en = 1'b1;

        for (int w = 0; w < 64; w++) do_req(1'b1, 3'b010, 32'(w * 4), $urandom, 0, '0, 1'b0, 0);
        wait_idle();

        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1, 32'h0, 1'b0, 0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 1, 32'hDEADBEEF, 1'b0, 0);
        do_req(1'b1, 3'b000, 32'h11, 32'h0000007F, 1, 32'h0, 1'b0, 0);
        do_req(1'b0, 3'b000, 32'h11, 32'h0, 1, 32'h0000007F, 1'b0, 0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 1, 32'hDEAD7FEF, 1'b0, 0);
        do_req(1'b0, 3'b100, 32'h13, 32'h0, 1, 32'h000000DE, 1'b0, 0);
        do_req(1'b0, 3'b001, 32'h12, 32'h0, 1, 32'hFFFFDEAD, 1'b0, 0);
        do_req(1'b0, 3'b010, 32'h12, 32'h0, 1, 32'h0, 1'b1, 0);
        do_req(1'b1, 3'b001, 32'h13, 32'h0000AAAA, 1, 32'h0, 1'b1, 0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 1, 32'hDEAD7FEF, 1'b0, 0);
        do_req(1'b0, 3'b010, 32'h100, 32'h0, 1, 32'h0, 1'b1, 0);
        do_req(1'b0, 3'b011, 32'h10, 32'h0, 1, 32'h0, 1'b1, 0);
        do_req(1'b1, 3'b100, 32'h10, 32'h0, 1, 32'h0, 1'b1, 0);
        wait_idle();

        // Stall the response for five cycles with resp_ready low.
        forced_rdy = 1'b0;
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, '0, 1'b0, 0);
        t = 0;
        while (!mon_resp_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("hold_resp_valid_seen", 32'(mon_resp_valid), 32'd1);
        repeat (4) @(negedge clk);
        forced_rdy = 1'b1;
        wait_idle();

        rand_rdy = 1'b1;
        repeat (300) begin
            logic [31:0] a;
            a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 271));
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                   0, '0, 1'b0, 0);
        end
        wait_idle();
        rand_rdy = 1'b0;

        sel = 1'b1;
        @(negedge clk);
        do_req(1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 1, 32'h0, 1'b0, 0);
        do_req(1'b0, 3'b010, 32'h20, 32'h0, 1, 32'hCAFEF00D, 1'b0, 0);
        wait_idle();
        // Store accepted, then reset lands while it sits in the wait state.
        do_req(1'b1, 3'b010, 32'h20, 32'h12345678, 0, '0, 1'b0, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_req_ready", 32'(bus3.req_ready), 32'd1);
        check("abort_resp_valid", 32'(bus3.resp_valid), 32'd0);
        do_req(1'b0, 3'b010, 32'h20, 32'h0, 1, 32'hCAFEF00D, 1'b0, 0);
        do_req(1'b0, 3'b101, 32'h22, 32'h0, 1, 32'h0000CAFE, 1'b0, 0);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
